ltc2333_controller: RTL and testbench

- FPGA-side initiator for the LTC2333 8-channel 18-bit SAR ADC serial port.
- On a start request it pulses CNV, waits for BUSY to complete, then clocks SCKI to read one 24-bit word per sequence entry.
- During that read it can optionally shift a new SoftSpan sequence out on SDI.
- Sits between the BPM acquisition sequencer (start/results) and the ADC pins; pairs with the existing LTC2333 device model in simulation.

---
 rtl/ltc2333_controller_if.sv | 40 ++++
 rtl/ltc2333_controller.sv | 221 ++++++++++++++++++++++
 tb/tb_ltc2333_controller.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ltc2333_controller_if.sv
// Signal bundle between the BPM acquisition sequencer, ltc2333_controller and the LTC2333 pins.
// Optional echo-check outputs exist only when LTC2333_ECHO_CHECK_EN is defined.
interface ltc2333_controller_if;
  logic        start;
  logic [3:0]  seq_len;
  logic [63:0] seq_cmd;
  logic        cfg_write;
  logic        idle;
  logic        done;
  logic        timeout;
  logic        res_valid;
  logic [17:0] res_data;
  logic [2:0]  res_chan;
  logic [2:0]  res_span;
  logic        cnv;
  logic        scki;
  logic        sdi;
  logic        busy;
  logic        sdo;
`ifdef LTC2333_ECHO_CHECK_EN
  logic        echo_err;
  logic        echo_err_any;
`endif

  modport master (
`ifdef LTC2333_ECHO_CHECK_EN
    output echo_err, echo_err_any,
`endif
    input  start, seq_len, seq_cmd, cfg_write, busy, sdo,
    output idle, done, timeout, res_valid, res_data, res_chan, res_span, cnv, scki, sdi
  );

  modport slave (
`ifdef LTC2333_ECHO_CHECK_EN
    input  echo_err, echo_err_any,
`endif
    output start, seq_len, seq_cmd, cfg_write, busy, sdo,
    input  idle, done, timeout, res_valid, res_data, res_chan, res_span, cnv, scki, sdi
  );
endinterface

// File: rtl/ltc2333_controller.sv
// LTC2333 serial-port initiator: CNV pulse, BUSY handshake, 24-bit word readout with optional
// SoftSpan programming on SDI. Define LTC2333_ECHO_CHECK_EN to add channel/span echo checking.
module ltc2333_controller #(
  parameter int unsigned CLK_DIV         = 2,
  parameter int unsigned CNV_HIGH_CYCLES = 4,
  parameter int unsigned BUSY_TIMEOUT    = 1024,
  parameter int unsigned SEQ_DEPTH       = 8
) (
  input logic                  clk,
  input logic                  rstn,
  ltc2333_controller_if.master bus
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CntW = $clog2(BUSY_TIMEOUT + CNV_HIGH_CYCLES + 1);
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] CnvLast = CntW'(CNV_HIGH_CYCLES - 1);
  localparam logic [CntW-1:0] ToLast  = CntW'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StCnv, StWaitHi, StWaitLo, StShift, StDone} state_e;

  state_e          r_state;
  logic            r_busy_meta, r_busy_sync;
  logic [3:0]      r_len;
  logic [63:0]     r_cmd;
  logic            r_cfg;
  logic [CntW-1:0] r_cnt;
  logic [DivW-1:0] r_div;
  logic [7:0]      r_rise;
  logic [4:0]      r_bitc;
  logic [22:0]     r_sr;
  logic            r_idle, r_done, r_timeout, r_res_valid;
  logic [17:0]     r_res_data;
  logic [2:0]      r_res_chan, r_res_span;
  logic            r_cnv, r_scki, r_sdi;

  logic [3:0]  w_len;
  logic [7:0]  w_n;
  logic [7:0]  w_cfg_bits;
  logic [5:0]  w_sdi_idx;
  logic        w_sdi_next;
  logic [23:0] w_word;

  always_comb begin
    w_len = bus.seq_len;
    if (bus.seq_len == 4'd0 || 32'(bus.seq_len) > SEQ_DEPTH) w_len = 4'(SEQ_DEPTH);
  end

  // N = 24*len SCKI periods; only the first 8*len bits may carry sequence data.
  assign w_n        = {r_len, 4'b0000} + {1'b0, r_len, 3'b000};
  assign w_cfg_bits = {1'b0, r_len, 3'b000};
  // Bit k is bit 7-(k%8) of byte k/8, i.e. seq_cmd[{k/8, ~k[2:0]}].
  assign w_sdi_idx  = {r_rise[5:3], ~r_rise[2:0]};
  assign w_sdi_next = r_cfg && (r_rise < w_cfg_bits) && r_cmd[w_sdi_idx];
  assign w_word     = {r_sr, bus.sdo};

`ifdef LTC2333_ECHO_CHECK_EN
  logic [2:0]  r_word;
  logic [63:0] r_prog;
  logic        r_echo_err, r_echo_err_any;
  logic [5:0]  w_echo_exp;

  assign w_echo_exp       = r_prog[{r_word, 3'b000} +: 6];
  assign bus.echo_err     = r_echo_err;
  assign bus.echo_err_any = r_echo_err_any;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_busy_meta <= 1'b0;
      r_busy_sync <= 1'b0;
    end else begin
      r_busy_meta <= bus.busy;
      r_busy_sync <= r_busy_meta;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= StIdle;
      r_len       <= '0;
      r_cmd       <= '0;
      r_cfg       <= 1'b0;
      r_cnt       <= '0;
      r_div       <= '0;
      r_rise      <= '0;
      r_bitc      <= '0;
      r_sr        <= '0;
      r_idle      <= 1'b1;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_chan  <= '0;
      r_res_span  <= '0;
      r_cnv       <= 1'b0;
      r_scki      <= 1'b0;
      r_sdi       <= 1'b0;
`ifdef LTC2333_ECHO_CHECK_EN
      r_word         <= '0;
      r_prog         <= '0;
      r_echo_err     <= 1'b0;
      r_echo_err_any <= 1'b0;
`endif
    end else begin
      r_res_valid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_len     <= w_len;
            r_cmd     <= bus.seq_cmd;
            r_cfg     <= bus.cfg_write;
            r_timeout <= 1'b0;
            r_cnv     <= 1'b1;
            r_cnt     <= '0;
            r_rise    <= '0;
            r_idle    <= 1'b0;
            r_state   <= StCnv;
`ifdef LTC2333_ECHO_CHECK_EN
            r_echo_err_any <= 1'b0;
`endif
          end
        end
        StCnv: begin
          if (r_cnt == CnvLast) begin
            r_cnv   <= 1'b0;
            r_cnt   <= '0;
            r_state <= StWaitHi;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StWaitHi: begin
          if (r_busy_sync) begin
            r_cnt   <= '0;
            r_state <= StWaitLo;
          end else if (r_cnt == ToLast) begin
            r_timeout <= 1'b1;
            r_idle    <= 1'b1;
            r_state   <= StIdle;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StWaitLo: begin
          if (!r_busy_sync) begin
            r_div   <= '0;
            r_bitc  <= '0;
            r_scki  <= 1'b0;
            r_sdi   <= w_sdi_next;
            r_state <= StShift;
`ifdef LTC2333_ECHO_CHECK_EN
            r_word <= '0;
`endif
          end else if (r_cnt == ToLast) begin
            r_timeout <= 1'b1;
            r_idle    <= 1'b1;
            r_state   <= StIdle;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StShift: begin
          if (r_div == DivLast) begin
            r_div <= '0;
            if (!r_scki) begin
              r_scki <= 1'b1;
              r_rise <= r_rise + 8'd1;
            end else begin
              // Falling edge: sample SDO and advance SDI in the same cycle.
              r_scki <= 1'b0;
              r_sdi  <= w_sdi_next;
              r_sr   <= w_word[22:0];
              if (r_bitc == 5'd23) begin
                r_bitc      <= '0;
                r_res_valid <= 1'b1;
                r_res_data  <= w_word[23:6];
                r_res_chan  <= w_word[5:3];
                r_res_span  <= w_word[2:0];
`ifdef LTC2333_ECHO_CHECK_EN
                r_word     <= r_word + 3'd1;
                r_echo_err <= (w_word[5:0] != w_echo_exp);
                if (w_word[5:0] != w_echo_exp) r_echo_err_any <= 1'b1;
`endif
              end else begin
                r_bitc <= r_bitc + 5'd1;
              end
              if (r_rise == w_n) begin
                r_done  <= 1'b1;
                r_state <= StDone;
              end
            end
          end else begin
            r_div <= r_div + 1'b1;
          end
        end
        StDone: begin
          r_done  <= 1'b0;
          r_idle  <= 1'b1;
          r_state <= StIdle;
`ifdef LTC2333_ECHO_CHECK_EN
          if (r_cfg) r_prog <= r_cmd;
`endif
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.idle      = r_idle;
  assign bus.done      = r_done;
  assign bus.timeout   = r_timeout;
  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_res_data;
  assign bus.res_chan  = r_res_chan;
  assign bus.res_span  = r_res_span;
  assign bus.cnv       = r_cnv;
  assign bus.scki      = r_scki;
  assign bus.sdi       = r_sdi;

endmodule

// File: tb/tb_ltc2333_controller.sv
// Bench for ltc2333_controller: behavioural LTC2333 model, result scoreboard, vector table and
// hand-written corner sequences (timeout, early BUSY, start during read, mid-run reset).
module tb_ltc2333_controller;
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  ltc2333_controller_if bus ();

  ltc2333_controller #(
    .CLK_DIV(2), .CNV_HIGH_CYCLES(4), .BUSY_TIMEOUT(1024), .SEQ_DEPTH(8)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );

  typedef struct {
    logic [3:0]  len;
    logic [63:0] cmd;
    logic        cfg;
    int          exp_len;
    bit          raw;
    bit          chk_cs;
    logic [5:0]  first_cs;
    logic [5:0]  last_cs;
    bit          chk_data;
    logic [17:0] last_data;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int mon_cnv, mon_rise, mon_valid, mon_done, m_fall, m_busy_left, m_prog_len;
  bit m_raw_en, m_busy_low, m_busy_hi, m_cnv_d, m_scki_d;
  logic [23:0] m_raw [8];
  logic [17:0] m_data [8];
  logic [7:0]  m_prog [8];
  logic [5:0]  mon_first;
  bit          m_cap [$];
  logic [23:0] sb_q [$];
  vec_t        vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] model_word(input int w);
    int wi;
    logic [7:0] e;
    wi = (w > 7) ? 7 : w;
    if (m_raw_en) return m_raw[wi];
    e = m_prog[wi % m_prog_len];
    return {m_data[wi], e[5:0]};
  endfunction

  function automatic logic model_bit();
    logic [23:0] wd;
    wd = model_word(m_fall / 24);
    return wd[23 - (m_fall % 24)];
  endfunction

  // ADC adopts a new sequence when the read shifted in bytes with bit7 set.
  task automatic load_prog();
    int nb;
    logic [7:0] b;
    nb = 0;
    for (int i = 0; i < 8; i++) begin
      if (m_cap.size() >= 8 * (i + 1) && nb == i) begin
        for (int j = 0; j < 8; j++) b[7-j] = m_cap[8*i+j];
        if (b[7]) begin
          m_prog[i] = b;
          nb++;
        end
      end
    end
    if (nb > 0) m_prog_len = nb;
  endtask

  // ADC model and monitor, evaluated away from the active clock edge.
  always @(negedge clk) begin
    logic [23:0] wexp;
    if (bus.cnv && !m_cnv_d) begin
      m_busy_left = 30;
      m_fall = 0;
      m_cap.delete();
    end
    m_cnv_d = bus.cnv;
    if (bus.cnv) mon_cnv++;
    if (bus.scki && !m_scki_d) begin
      mon_rise++;
      m_cap.push_back(bus.sdi);
    end
    if (!bus.scki && m_scki_d) m_fall++;
    m_scki_d = bus.scki;
    if (bus.res_valid) begin
      if (mon_valid == 0) mon_first = {bus.res_chan, bus.res_span};
      mon_valid++;
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got word %0h expected none",
                 {bus.res_data, bus.res_chan, bus.res_span});
      end else begin
        wexp = sb_q.pop_front();
        check("sb_word", {bus.res_data, bus.res_chan, bus.res_span}, wexp);
      end
    end
    if (bus.done) begin
      mon_done++;
      load_prog();
    end
    bus.busy = m_busy_hi || (!m_busy_low && m_busy_left > 0);
    if (m_busy_left > 0) m_busy_left--;
    bus.sdo = model_bit();
  end

  task automatic clear_mon();
    mon_cnv = 0;
    mon_rise = 0;
    mon_valid = 0;
    mon_done = 0;
  endtask

  task automatic pulse_start(input logic [3:0] len, input logic [63:0] cmd, input logic cfg);
    bus.seq_len = len;
    bus.seq_cmd = cmd;
    bus.cfg_write = cfg;
    bus.start = 1'b1;
    @(negedge clk); #1;
    bus.start = 1'b0;
    // Scramble inputs to prove they were latched on acceptance.
    bus.seq_len = 4'd1;
    bus.seq_cmd = ~cmd;
    bus.cfg_write = ~cfg;
  endtask

  task automatic wait_done(input int limit, input bit extra, output bit got);
    bit pulsed;
    got = 1'b0;
    pulsed = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      @(negedge clk); #1;
      if (mon_done > 0) got = 1'b1;
      if (extra && !pulsed && bus.scki) begin
        bus.start = 1'b1;
        @(negedge clk); #1;
        bus.start = 1'b0;
        pulsed = 1'b1;
      end
    end
  endtask

  task automatic run_conv(input logic [3:0] len, input logic [63:0] cmd, input logic cfg,
                          input int exp_len, input bit extra);
    bit got;
    int bad;
    bit eb;
    @(negedge clk); #1;
    clear_mon();
    for (int w = 0; w < exp_len; w++) begin
      m_data[w] = 18'($urandom);
      sb_q.push_back(model_word(w));
    end
    pulse_start(len, cmd, cfg);
    wait_done(20000, extra, got);
    check("done_seen", got, 1);
    repeat (5) @(negedge clk);
    #1;
    check("cnv_width", mon_cnv, 4);
    check("scki_rises", mon_rise, 24 * exp_len);
    check("res_valid_count", mon_valid, exp_len);
    check("done_count", mon_done, 1);
    check("idle_after", bus.idle, 1);
    check("timeout_clear", bus.timeout, 0);
    check("sb_drained", sb_q.size(), 0);
    bad = (m_cap.size() == 24 * exp_len) ? 0 : 1;
    for (int k = 0; k < m_cap.size(); k++) begin
      eb = (cfg && k < 8 * exp_len) ? cmd[8*(k/8) + 7 - (k%8)] : 1'b0;
      if (m_cap[k] !== eb) bad++;
    end
    check("sdi_stream_errors", bad, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    bit   got;
    logic [63:0] rcmd;
    rcmd = {$urandom, $urandom} | 64'h8080_8080_8080_8080;
    vecs[0] = '{4'd1, 64'h0, 1'b0, 1, 1'b1, 1'b1, 6'o57, 6'o57, 1'b1, 18'h2AF37};
    vecs[1] = '{4'd2, 64'h829D, 1'b1, 2, 1'b0, 1'b1, 6'o00, 6'o10, 1'b0, 18'h0};
    vecs[2] = '{4'd2, 64'h0, 1'b0, 2, 1'b0, 1'b1, 6'o35, 6'o02, 1'b0, 18'h0};
    vecs[3] = '{4'd0, 64'h0123_4567_89ab_cdef, 1'b0, 8, 1'b0, 1'b0, 6'o0, 6'o0, 1'b0, 18'h0};
    vecs[4] = '{4'd9, rcmd, 1'b1, 8, 1'b0, 1'b0, 6'o0, 6'o0, 1'b0, 18'h0};
    vecs[5] = '{4'd15, 64'h0, 1'b0, 8, 1'b0, 1'b0, 6'o0, 6'o0, 1'b0, 18'h0};
    vecs[6] = '{4'd3, 64'h0, 1'b0, 3, 1'b0, 1'b0, 6'o0, 6'o0, 1'b0, 18'h0};
    for (int i = 0; i < 8; i++) m_prog[i] = {2'b10, 3'(i), 3'b000};
    m_prog_len = 8;
    m_raw[0] = 24'habcdef;
    for (int i = 1; i < 8; i++) m_raw[i] = 24'h0;
    m_raw_en = 1'b0;
    m_busy_low = 1'b0;
    m_busy_hi = 1'b0;
    bus.start = 1'b0;
    bus.seq_len = 4'd0;
    bus.seq_cmd = 64'h0;
    bus.cfg_write = 1'b0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_idle", bus.idle, 1);
    check("rst_ctl", {bus.cnv, bus.scki, bus.sdi, bus.done, bus.res_valid, bus.timeout}, 0);
    check("rst_res", {bus.res_data, bus.res_chan, bus.res_span}, 0);
    rstn = 1'b1;

    for (int i = 0; i < 7; i++) begin
      m_raw_en = vecs[i].raw;
      run_conv(vecs[i].len, vecs[i].cmd, vecs[i].cfg, vecs[i].exp_len, 1'b0);
      if (vecs[i].chk_cs) begin
        check("first_chan_span", mon_first, vecs[i].first_cs);
        check("last_chan_span", {bus.res_chan, bus.res_span}, vecs[i].last_cs);
      end
      if (vecs[i].chk_data) check("res_data_hold", bus.res_data, vecs[i].last_data);
    end
    m_raw_en = 1'b0;

`ifdef LTC2333_ECHO_CHECK_EN
    m_prog[0] = m_prog[0] ^ 8'h07;
    run_conv(4'd1, 64'h0, 1'b0, 1, 1'b0);
    check("echo_err_set", bus.echo_err, 1);
    check("echo_err_any_set", bus.echo_err_any, 1);
    m_prog[0] = m_prog[0] ^ 8'h07;
    run_conv(4'd1, 64'h0, 1'b0, 1, 1'b0);
    check("echo_err_clr", bus.echo_err, 0);
    check("echo_err_any_clr", bus.echo_err_any, 0);
`endif

    // Start during the read is dropped.
    run_conv(4'd3, 64'h0, 1'b0, 3, 1'b1);

    // BUSY never rises: timeout from the high-wait, no serial activity.
    m_busy_low = 1'b1;
    @(negedge clk); #1;
    clear_mon();
    pulse_start(4'd1, 64'h0, 1'b0);
    repeat (995) @(negedge clk);
    #1;
    check("to_not_early", {bus.timeout, bus.idle}, 2'b00);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk); #1;
      if (bus.timeout) got = 1'b1;
    end
    check("to_set", got, 1);
    check("to_idle", bus.idle, 1);
    check("to_no_scki", mon_rise, 0);
    check("to_no_result", {mon_valid, mon_done}, 0);
    m_busy_low = 1'b0;
    run_conv(4'd1, 64'h0, 1'b0, 1, 1'b0);

    // BUSY already high before CNV.
    m_busy_hi = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    clear_mon();
    m_data[0] = 18'($urandom);
    sb_q.push_back(model_word(0));
    pulse_start(4'd1, 64'h0, 1'b0);
    repeat (60) @(negedge clk);
    #1;
    check("bh_waiting", {bus.idle, bus.timeout, 8'(mon_rise)}, 0);
    m_busy_hi = 1'b0;
    wait_done(2000, 1'b0, got);
    check("bh_done", got, 1);
    check("bh_valid", mon_valid, 1);

    // Asynchronous reset in the middle of a read.
    @(negedge clk); #1;
    clear_mon();
    for (int w = 0; w < 8; w++) begin
      m_data[w] = 18'($urandom);
      sb_q.push_back(model_word(w));
    end
    pulse_start(4'd8, 64'h0, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk); #1;
      if (mon_valid >= 2) got = 1'b1;
    end
    check("rr_progress", got, 1);
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    check("rr_ctl", {bus.cnv, bus.scki, bus.sdi, bus.done, bus.res_valid, bus.timeout}, 0);
    check("rr_res", {bus.res_data, bus.res_chan, bus.res_span}, 0);
    check("rr_idle", bus.idle, 1);
    sb_q.delete();
    repeat (3) @(negedge clk);
    #1;
    rstn = 1'b1;
    clear_mon();
    repeat (400) @(negedge clk);
    #1;
    check("rr_quiet", {mon_valid, mon_done, mon_rise}, 0);
    check("rr_idle_after", bus.idle, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
